cmd_router: RTL and testbench
=============================

# cmd_router

Parametrised command router for the daisy-chained control bus, the next generation of the per-node command splitter. Every accepted command is classified against the node's assigned device ID. It is delivered to the local register decoders, forwarded downstream through a buffered, back-pressured transmit path, or both. The block also implements broadcast ID enumeration and a downstream-stall watchdog that drops stuck commands and counts them.

## Interface
- DW, 8: width of each command field (dev, mod, addr, data).
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, ≥2.
- BCAST_ID, {DW{1'b1}}: broadcast device address.
- ID_INC, 1: increment applied to the enumeration data field.
- TMO_US, 1000: downstream stall limit in pluse_us ticks, 1..65535.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pluse_us  in  1  1-cycle pulse every microsecond.
- cmdr_dev / cmdr_mod / cmdr_addr / cmdr_data  in  DW each  received command fields.
- cmdr_vld  in  1  received command valid.
- cmdr_rdy  out  1  router can accept; transfer = cmdr_vld & cmdr_rdy.
- cmdt_dev / cmdt_mod / cmdt_addr / cmdt_data  out  DW each  transmit command (FIFO head).
- cmdt_vld  out  1  transmit valid.
- cmdt_rdy  in  1  downstream ready; pop = cmdt_vld & cmdt_rdy.
- cmdl_dev / cmdl_mod / cmdl_addr / cmdl_data  out  DW each  local command.
- cmdl_vld  out  1  local command strobe, 1 cycle, no back-pressure.
- dev_id  out  DW  assigned device ID.
- id_valid  out  1  dev_id has been assigned since reset.
- drop_cnt  out  16  commands dropped by watchdog, saturating at 16'hFFFF.
- tmo_pulse  out  1  1-cycle pulse per watchdog drop.

## Operation
- Classification applies to the command presented on an accepted cycle only:
  - broadcast = (cmdr_dev == BCAST_ID).
  - localhost = id_valid & ~broadcast & (cmdr_dev == dev_id).
  - setid = broadcast & cmdr_mod == 0 & cmdr_addr == 0.
- setid accept: dev_id <= cmdr_data + ID_INC (mod 2^DW) and id_valid <= 1. A later setid overwrites both.
- Local path: accept & (broadcast | localhost) → cmdl_* <= cmdr_* unmodified, cmdl_vld <= 1 for one cycle. Otherwise cmdl_vld <= 0. cmdl_* hold their last value.
- Transmit path: accept & ~localhost → push {dev, mod, addr, data'} into the FIFO. data' = cmdr_data + ID_INC for setid, else cmdr_data.
- cmdr_rdy = rst_n & ~full. No push while full, even when a pop happens in the same cycle.
- Localhost commands consume no FIFO space, but are still refused while full because cmdr_rdy is shared.
- cmdt_vld = ~empty. cmdt_* show the FIFO head and stay stable while cmdt_vld & ~cmdt_rdy.
- Simultaneous push and pop when not full: occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Watchdog FSM:
  - IDLE: entered while empty or on any pop; tick counter cleared.
  - STALL: entered when cmdt_vld & ~cmdt_rdy; counts pluse_us ticks.
  - DROP: entered when the count reaches TMO_US and cmdt_rdy is still low. For one cycle, discard the head (internal pop), assert tmo_pulse, drop_cnt +1 saturating. Then go to IDLE.
  - cmdt_rdy high in the same cycle as the TMO_US-th tick: normal pop, no drop.
  - A push in the DROP cycle is accepted normally.
- dev_id == BCAST_ID after a wrap (e.g. data FE, ID_INC 1): the node has no unicast address; BCAST_ID traffic is still treated as broadcast.

## Timing
- Reset (rst_n low at a clock edge), all registers cleared:
  - dev_id=0, id_valid=0, drop_cnt=0, tmo_pulse=0.
  - cmdl_vld=0, cmdl_*=0.
  - FIFO emptied, so cmdt_vld=0; cmdt_* read 0.
  - cmdr_rdy=0 while rst_n is low; 1 on the first cycle after release.
- Reset mid-operation: buffered commands are lost, watchdog returns to IDLE, no tmo_pulse.
- Accept on edge N:
  - cmdl_vld and cmdl_* valid at N+1.
  - dev_id and id_valid updated at N+1.
  - Forwarded command: cmdt_vld high at N+1 when the FIFO was empty (one-cycle first-word latency).
- Throughput: one accept per cycle; one pop per cycle.
- Watchdog: drop happens in the cycle after the TMO_US-th pluse_us tick observed in STALL. Timeout granularity is ±1 µs.

## Test plan
- Enumeration: reset, send dev=FF mod=0 addr=0 data=03 → dev_id=04, id_valid=1 at N+1; cmdl_vld 1 cycle with data=03; cmdt data=04.
- Unicast: with dev_id=04, send dev=04 → cmdl only, FIFO unchanged. Send dev=07 → cmdt only, cmdl_vld stays 0. Before any setid, dev=00 is forwarded, not local.
- Back-pressure: cmdt_rdy=0, push FIFO_DEPTH commands → cmdr_rdy=0. Raise cmdt_rdy → commands emerge in order with no loss or duplicates, and cmdr_rdy returns to 1 one cycle after the first pop.
- Watchdog: TMO_US=3, cmdt_rdy held 0, one entry → drop after the 3rd pluse_us; tmo_pulse 1 cycle; drop_cnt=1; cmdt_vld falls. Raising cmdt_rdy on the 3rd tick instead → normal pop, drop_cnt=0.
- Wrap/boundary: setid with data=FE → dev_id=FF. A following dev=FF command reaches both paths. drop_cnt saturates at FFFF after forced drops.
- Reset mid-stream: assert rst_n low with the FIFO at 3 entries and the watchdog in STALL → all outputs at reset values next edge, no tmo_pulse, FIFO empty after release.

Source files
------------

// File: rtl/cmd_router.sv
// cmd_router: per-node command router for the daisy-chained control bus.
//
// Each accepted command is classified against this node's device ID and is
// delivered to the local decoders (cmdl_*), forwarded downstream through a
// FIFO (cmdt_*), or both. Broadcast commands with mod==0 and addr==0 assign the
// device ID (enumeration). A watchdog drops the FIFO head when downstream
// stalls for TMO_US microsecond ticks.
//
// Ports:
//   clk_sys, rst_n         clock, synchronous active-low reset
//   pluse_us               1-cycle tick every microsecond
//   cmdr_*                 receive command + valid/ready handshake
//   cmdt_*                 transmit command (FIFO head) + valid/ready handshake
//   cmdl_*                 local command strobe (1 cycle, no back-pressure)
//   dev_id, id_valid       assigned device ID and assigned flag
//   drop_cnt, tmo_pulse    watchdog drop counter (saturating) and drop pulse
module cmd_router #(
    parameter int              DW         = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [DW-1:0]   BCAST_ID   = {DW{1'b1}},
    parameter int              ID_INC     = 1,
    parameter int              TMO_US     = 1000
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          pluse_us,
    input  logic [DW-1:0] cmdr_dev,
    input  logic [DW-1:0] cmdr_mod,
    input  logic [DW-1:0] cmdr_addr,
    input  logic [DW-1:0] cmdr_data,
    input  logic          cmdr_vld,
    output logic          cmdr_rdy,
    output logic [DW-1:0] cmdt_dev,
    output logic [DW-1:0] cmdt_mod,
    output logic [DW-1:0] cmdt_addr,
    output logic [DW-1:0] cmdt_data,
    output logic          cmdt_vld,
    input  logic          cmdt_rdy,
    output logic [DW-1:0] cmdl_dev,
    output logic [DW-1:0] cmdl_mod,
    output logic [DW-1:0] cmdl_addr,
    output logic [DW-1:0] cmdl_data,
    output logic          cmdl_vld,
    output logic [DW-1:0] dev_id,
    output logic          id_valid,
    output logic [15:0]   drop_cnt,
    output logic          tmo_pulse
);
    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0]   INC      = DW'(ID_INC);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]     TMO_LAST = 16'(TMO_US - 1);

    typedef enum logic [1:0] {WD_IDLE, WD_STALL, WD_DROP} wd_state_t;

    logic [4*DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    wd_state_t       r_wd_state;
    logic [15:0]     r_ticks;
    logic [15:0]     r_drop_cnt;
    logic            r_tmo_pulse;
    logic [DW-1:0]   r_dev_id;
    logic            r_id_valid;
    logic [4*DW-1:0] r_cmdl;
    logic            r_cmdl_vld;

    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_bcast;
    logic            w_local;
    logic            w_setid;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [DW-1:0]   w_data_fwd;
    logic [4*DW-1:0] w_head;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign cmdr_rdy = rst_n & ~w_full;
    assign w_accept = cmdr_vld & cmdr_rdy;

    // A node whose ID wrapped to BCAST_ID has no unicast address: the
    // ~w_bcast term keeps such traffic on the broadcast path.
    assign w_bcast    = (cmdr_dev == BCAST_ID);
    assign w_local    = r_id_valid & ~w_bcast & (cmdr_dev == r_dev_id);
    assign w_setid    = w_bcast & (cmdr_mod == '0) & (cmdr_addr == '0);
    assign w_data_fwd = w_setid ? cmdr_data + INC : cmdr_data;

    assign w_push = w_accept & ~w_local;
    // The DROP state discards the head exactly like a downstream pop; if the
    // downstream also takes it that cycle it is still only one pop.
    assign w_drop = (r_wd_state == WD_DROP);
    assign w_pop  = ~w_empty & (cmdt_rdy | w_drop);

    // Head is gated so the transmit bus reads zero when nothing is queued.
    assign w_head   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign cmdt_vld = ~w_empty;
    assign {cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data} = w_head;

    assign {cmdl_dev, cmdl_mod, cmdl_addr, cmdl_data} = r_cmdl;
    assign cmdl_vld  = r_cmdl_vld;
    assign dev_id    = r_dev_id;
    assign id_valid  = r_id_valid;
    assign drop_cnt  = r_drop_cnt;
    assign tmo_pulse = r_tmo_pulse;

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmdr_dev, cmdr_mod, cmdr_addr, w_data_fwd};
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_cmdl     <= '0;
            r_cmdl_vld <= 1'b0;
            r_dev_id   <= '0;
            r_id_valid <= 1'b0;
        end else begin
            r_cmdl_vld <= w_accept & (w_bcast | w_local);
            if (w_accept & (w_bcast | w_local))
                r_cmdl <= {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data};
            if (w_accept & w_setid) begin
                r_dev_id   <= cmdr_data + INC;
                r_id_valid <= 1'b1;
            end
        end
    end

    // Watchdog: counts ticks only while the head is blocked; any pop or an
    // empty FIFO returns to IDLE. tmo_pulse and drop_cnt update on entry to
    // DROP so they line up with the cycle in which the head is discarded.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_wd_state  <= WD_IDLE;
            r_ticks     <= '0;
            r_tmo_pulse <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_tmo_pulse <= 1'b0;
            case (r_wd_state)
                WD_IDLE: begin
                    r_ticks <= '0;
                    if (~w_empty & ~cmdt_rdy) r_wd_state <= WD_STALL;
                end
                WD_STALL: begin
                    if (w_empty | cmdt_rdy) begin
                        r_wd_state <= WD_IDLE;
                        r_ticks    <= '0;
                    end else if (pluse_us) begin
                        if (r_ticks == TMO_LAST) begin
                            r_wd_state  <= WD_DROP;
                            r_ticks     <= '0;
                            r_tmo_pulse <= 1'b1;
                            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                        end else begin
                            r_ticks <= r_ticks + 16'd1;
                        end
                    end
                end
                WD_DROP: begin
                    r_wd_state <= WD_IDLE;
                    r_ticks    <= '0;
                end
                default: begin
                    r_wd_state <= WD_IDLE;
                    r_ticks    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_router.sv
module tb_cmd_router;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 3;

    logic          clk_sys = 1'b0;
    logic          rst_n;
    logic          pluse_us;
    logic [DW-1:0] cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data;
    logic          cmdr_vld, cmdr_rdy;
    logic [DW-1:0] cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data;
    logic          cmdt_vld, cmdt_rdy;
    logic [DW-1:0] cmdl_dev, cmdl_mod, cmdl_addr, cmdl_data;
    logic          cmdl_vld;
    logic [DW-1:0] dev_id;
    logic          id_valid;
    logic [15:0]   drop_cnt;
    logic          tmo_pulse;

    cmd_router #(.DW(DW), .FIFO_DEPTH(DEPTH), .BCAST_ID(8'hFF), .ID_INC(1), .TMO_US(TMO)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .pluse_us(pluse_us),
        .cmdr_dev(cmdr_dev), .cmdr_mod(cmdr_mod), .cmdr_addr(cmdr_addr), .cmdr_data(cmdr_data),
        .cmdr_vld(cmdr_vld), .cmdr_rdy(cmdr_rdy),
        .cmdt_dev(cmdt_dev), .cmdt_mod(cmdt_mod), .cmdt_addr(cmdt_addr), .cmdt_data(cmdt_data),
        .cmdt_vld(cmdt_vld), .cmdt_rdy(cmdt_rdy),
        .cmdl_dev(cmdl_dev), .cmdl_mod(cmdl_mod), .cmdl_addr(cmdl_addr), .cmdl_data(cmdl_data),
        .cmdl_vld(cmdl_vld), .dev_id(dev_id), .id_valid(id_valid),
        .drop_cnt(drop_cnt), .tmo_pulse(tmo_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] mod;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    // Reference model: the forwarding queue, node identity, local strobe and
    // a blocked-head tick count.
    cmd_t        q[$];
    logic [7:0]  m_id;
    logic        m_idv;
    logic [15:0] m_drop;
    logic        m_tmo;
    logic        m_clv;
    cmd_t        m_cl;
    logic        m_blocked;
    int          m_ticks;
    logic        m_dropping;

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        cmd_t c, f;
        logic bc, lc, sid, acc, pop, busy;
        c = {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data};
        if (!rst_n) begin
            q.delete();
            m_id = 0; m_idv = 0; m_drop = 0; m_tmo = 0; m_clv = 0; m_cl = '0;
            m_blocked = 0; m_ticks = 0; m_dropping = 0;
            return;
        end
        busy = (q.size() != 0);
        acc  = cmdr_vld && (q.size() < DEPTH);
        bc   = (c.dev == 8'hFF);
        lc   = m_idv && !bc && (c.dev == m_id);
        sid  = bc && (c.mod == 0) && (c.addr == 0);
        pop  = busy && (cmdt_rdy || m_dropping);
        m_tmo = 0;
        if (m_dropping) begin
            m_dropping = 0; m_blocked = 0; m_ticks = 0;
        end else if (m_blocked) begin
            if (!busy || cmdt_rdy) begin
                m_blocked = 0; m_ticks = 0;
            end else if (pluse_us) begin
                m_ticks++;
                if (m_ticks == TMO) begin
                    m_dropping = 1; m_blocked = 0; m_ticks = 0; m_tmo = 1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
        end else if (busy && !cmdt_rdy) begin
            m_blocked = 1;
        end
        if (pop) void'(q.pop_front());
        if (acc && !lc) begin
            f = c;
            if (sid) f.data = c.data + 8'd1;
            q.push_back(f);
        end
        m_clv = acc && (bc || lc);
        if (m_clv) m_cl = c;
        if (acc && sid) begin
            m_id  = c.data + 8'd1;
            m_idv = 1;
        end
    endtask

    task automatic cmp_model();
        cmd_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("cmdr_rdy", cmdr_rdy, rst_n && (q.size() < DEPTH));
        chk("cmdt_vld", cmdt_vld, q.size() != 0);
        chk("cmdt_cmd", {cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data}, h);
        chk("cmdl_vld", cmdl_vld, m_clv);
        chk("cmdl_cmd", {cmdl_dev, cmdl_mod, cmdl_addr, cmdl_data}, m_cl);
        chk("dev_id", dev_id, m_id);
        chk("id_valid", id_valid, m_idv);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("tmo_pulse", tmo_pulse, m_tmo);
    endtask

    // One clock: model consumes the current inputs, DUT samples them at the
    // edge, outputs compared 1 ns later.
    task automatic cycle();
        model_step();
        @(posedge clk_sys);
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] m,
                         input logic [7:0] a, input logic [7:0] dt, input logic tr, input logic p);
        cmdr_vld = v; cmdr_dev = d; cmdr_mod = m; cmdr_addr = a; cmdr_data = dt;
        cmdt_rdy = tr; pluse_us = p;
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dev, mod, addr, data;
        logic       trdy;
        logic       clv;
        logic [7:0] cld;
        logic       ctv;
        logic [7:0] ctd;
        logic [7:0] id;
        logic       idv;
        logic       rdy;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // inputs: vld dev mod addr data cmdt_rdy | after edge: cmdl_vld cmdl_data cmdt_vld cmdt_data dev_id id_valid cmdr_rdy
        vecs[0]  = '{1'b1, 8'h00, 8'h01, 8'h02, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 8'h04, 8'h04, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 8'h04, 8'h05, 8'h06, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 8'h04, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 8'h07, 8'h00, 8'h00, 8'h33, 1'b0, 1'b0, 8'h22, 1'b1, 8'h33, 8'h04, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 1'b0, 8'h00, 8'h04, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 8'hFF, 8'h01, 8'h00, 8'h44, 1'b0, 1'b1, 8'h44, 1'b1, 8'h44, 8'h04, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b1, 8'h44, 8'hFF, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 8'hFF, 8'h02, 8'h03, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 8'h44, 8'hFF, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 8'h09, 8'h00, 8'h00, 8'h66, 1'b0, 1'b0, 8'h55, 1'b1, 8'h44, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h0A, 8'h00, 8'h00, 8'h77, 1'b1, 1'b0, 8'h55, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 8'h55, 8'hFF, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 8'h66, 8'hFF, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("reset_rdy_low", cmdr_rdy, 1'b0);
        chk("reset_cmdt_vld", cmdt_vld, 1'b0);
        chk("reset_dev_id", {id_valid, dev_id}, 9'h000);
        rst_n = 1'b1;
        cycle();
        chk("release_rdy", cmdr_rdy, 1'b1);

        // Classification, enumeration, ID wrap and back-pressure.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].vld, vecs[i].dev, vecs[i].mod, vecs[i].addr, vecs[i].data, vecs[i].trdy, 1'b0);
            cycle();
            chk($sformatf("vec%0d_cmdl_vld", i), cmdl_vld, vecs[i].clv);
            chk($sformatf("vec%0d_cmdl_data", i), cmdl_data, vecs[i].cld);
            chk($sformatf("vec%0d_cmdt_vld", i), cmdt_vld, vecs[i].ctv);
            chk($sformatf("vec%0d_cmdt_data", i), cmdt_data, vecs[i].ctd);
            chk($sformatf("vec%0d_dev_id", i), dev_id, vecs[i].id);
            chk($sformatf("vec%0d_id_valid", i), id_valid, vecs[i].idv);
            chk($sformatf("vec%0d_cmdr_rdy", i), cmdr_rdy, vecs[i].rdy);
        end

        // Watchdog drop: one stuck entry, three ticks while blocked.
        drive(1'b1, 8'h07, 8'h00, 8'h00, 8'hA1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < TMO; k++) begin
            pluse_us = 1'b1;
            cycle();
            pluse_us = 1'b0;
            if (k < TMO - 1) begin
                chk("wd_no_early_pulse", tmo_pulse, 1'b0);
                cycle();
            end
        end
        chk("wd_tmo_pulse", tmo_pulse, 1'b1);
        chk("wd_drop_cnt", drop_cnt, 16'd1);
        cycle();
        chk("wd_pulse_one_cycle", tmo_pulse, 1'b0);
        chk("wd_head_dropped", cmdt_vld, 1'b0);

        // Ready on the final tick wins: normal pop, no drop.
        drive(1'b1, 8'h07, 8'h00, 8'h00, 8'hA2, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < TMO - 1; k++) begin
            pluse_us = 1'b1;
            cycle();
        end
        pluse_us = 1'b1;
        cmdt_rdy = 1'b1;
        chk("wd_last_tick_data", cmdt_data, 8'hA2);
        cycle();
        pluse_us = 1'b0;
        chk("wd_rdy_no_pulse", tmo_pulse, 1'b0);
        chk("wd_rdy_drop_cnt", drop_cnt, 16'd1);
        chk("wd_rdy_popped", cmdt_vld, 1'b0);

        // Reset with three entries queued and the watchdog stalled.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h07, 8'h00, 8'h00, 8'(8'hB0 + k), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle();
        rst_n = 1'b0;
        pluse_us = 1'b1;
        cycle();
        chk("midrst_cmdt_vld", cmdt_vld, 1'b0);
        chk("midrst_rdy", cmdr_rdy, 1'b0);
        chk("midrst_tmo", tmo_pulse, 1'b0);
        chk("midrst_drop_cnt", drop_cnt, 16'd0);
        chk("midrst_id", {id_valid, dev_id}, 9'h000);
        rst_n = 1'b1;
        pluse_us = 1'b0;
        cycle();
        chk("midrst_after_rdy", cmdr_rdy, 1'b1);
        chk("midrst_after_empty", cmdt_vld, 1'b0);

        // Randomized traffic against the model; ready bias rotates so that
        // long stalls, drops and full-FIFO refusals all occur.
        for (int i = 0; i < 2400; i++) begin
            int rp;
            rp = (i / 100) % 3;
            rst_n     = ($urandom_range(0, 499) != 0);
            cmdr_vld  = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 3))
                0:       cmdr_dev = 8'hFF;
                1:       cmdr_dev = m_id;
                2:       cmdr_dev = 8'h00;
                default: cmdr_dev = 8'($urandom);
            endcase
            cmdr_mod  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            cmdr_addr = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            cmdr_data = 8'($urandom);
            if (rp == 0)      cmdt_rdy = ($urandom_range(0, 19) == 0);
            else if (rp == 1) cmdt_rdy = ($urandom_range(0, 1) == 0);
            else              cmdt_rdy = ($urandom_range(0, 9) != 0);
            pluse_us = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
